// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU pipeline types
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pl_skid_reg.sv
// rtl/pl_skid_reg.sv - two-entry pipeline skid register with flush
module pl_skid_reg
    import cpu_types_pkg::*;
#(
    parameter int                DATA_W    = 96,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic              out_flushed,
    output logic [1:0]        occupancy
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              flushed_q;
    logic              accept, drain;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= EMPTY;
            main_q    <= FLUSH_VAL;
            skid_q    <= FLUSH_VAL;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            flushed_q <= flush;
        end
    end

    // Every path into EMPTY reloads FLUSH_VAL, so out_data can be main_q directly.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = HALF;
                        main_d  = in_data;
                    end
                end
                HALF: begin
                    if (accept && drain) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                        main_d  = FLUSH_VAL;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d = HALF;
                        main_d  = skid_q;
                        skid_d  = FLUSH_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = FLUSH_VAL;
                    skid_d  = FLUSH_VAL;
                end
            endcase
        end
    end

    always_comb begin
        out_valid   = (state_q != EMPTY);
        in_ready    = (state_q != FULL);
        out_data    = main_q;
        out_flushed = flushed_q;
        case (state_q)
            HALF:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/pl_skid_reg.md
PL_SKID_REG -- requirements
Module: pl_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning payload width in bits (instruction, pcn and next_address of 32 bits each).
REQ-002 The block SHALL have parameter FLUSH_VAL, default all-zero DATA_W vector, meaning the value loaded into every storage entry on flush or reset.
REQ-003 Clock and reset SHALL be: reset nRST, asynchronous, active-low; clock CLK.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  block can accept this cycle; registered, derived from state only.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_data  output  DATA_W  head entry; equals FLUSH_VAL when empty.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 flush  input  1  synchronous kill of all held entries.
REQ-013 out_flushed  output  1  high for the one cycle following a flush.
REQ-014 occupancy  output  2  number of held entries, 0 to 2.

Function
REQ-015 Accept SHALL be in_valid && in_ready; drain SHALL be out_valid && out_ready.
REQ-016 Storage SHALL be a main entry driving out_data plus one skid entry, in FIFO order.
REQ-017 States SHALL be EMPTY (occupancy 0), HALF (1), FULL (2); out_valid = state != EMPTY; in_ready = state != FULL.
REQ-018 EMPTY: accept -> HALF with main <= in_data; otherwise stay EMPTY.
REQ-019 HALF: accept with drain -> HALF with main <= in_data; accept only -> FULL with skid <= in_data; drain only -> EMPTY with main <= FLUSH_VAL; neither -> hold.
REQ-020 FULL: drain -> HALF with main <= skid and skid <= FLUSH_VAL; no drain -> hold; no accept is possible.
REQ-021 Latency: an entry accepted into EMPTY SHALL appear on out_data with out_valid the next cycle; throughput SHALL be one transfer per cycle while downstream is ready.
REQ-022 flush SHALL have priority over accept and drain in the same cycle: next state EMPTY, main and skid <= FLUSH_VAL, out_flushed <= 1.
REQ-023 An upstream handshake that completes in a flush cycle SHALL count as accepted and then discarded; no replay.
REQ-024 A drain completing in a flush cycle SHALL count as delivered.
REQ-025 out_flushed SHALL be 0 in every cycle not immediately after a flush cycle; back-to-back flushes keep it high.
REQ-026 Held entries SHALL not change while no accept, drain or flush occurs, regardless of in_data.
REQ-027 FULL with out_ready held low SHALL hold indefinitely with in_ready low; no overwrite and no loss.

Reset
REQ-028 While nRST is low: state EMPTY, main and skid = FLUSH_VAL, out_valid 0, out_flushed 0, occupancy 0, in_ready 1.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately; out_flushed SHALL stay 0 after reset release.

Structure
REQ-030 The state enumeration skid_state_t (EMPTY, HALF, FULL) SHALL live in shared package cpu_types_pkg; DATA_W and FLUSH_VAL remain module parameters.
REQ-031 The block SHALL be a single module with no sub-module; pipeline stages instantiate it once per stage boundary with a packed payload struct.

Verification
REQ-032 Reset, then in_valid=1, in_data=0xA, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xA, occupancy=1, in_ready=1.
REQ-033 out_ready=0, push 0x1 then 0x2 -> occupancy=2, in_ready=0; push 0x3 held offered; raise out_ready -> outputs 0x1, 0x2, 0x3 in order, none lost.
REQ-034 FULL with flush=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, out_data=FLUSH_VAL, out_flushed=1; one cycle later out_flushed=0.
REQ-035 HALF with simultaneous accept 0x5 and drain -> occupancy stays 1, out_data=0x5; streaming 100 words at out_ready=1 -> 100 transfers in 100 consecutive cycles.
REQ-036 nRST pulsed low while FULL -> immediately occupancy=0, in_ready=1, out_flushed=0; a new push after reset release completes normally.
